alu_arbiter: RTL

//   Shares the single combinational ALU between two requesters (0 = execute

---
 rtl/alu_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Requester 0 is the execute stage and requester 1 is the branch/compare unit.
// Arbitration is round-robin with a valid/ready handshake. Only one operation
// is in flight at a time. The operands are held on the ALU inputs for a
// func-dependent number of cycles, and the result comes back on a registered
// response channel.
module alu_arbiter #(
    parameter int DATA_W     = 32,
    parameter int MULDIV_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    // requester 0 (execute stage)
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [5:0]        req0_func,
    // requester 1 (branch/compare unit)
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [5:0]        req1_func,
    // shared ALU
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [5:0]        alu_func,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    // response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              busy
);

    // Counter only has to hold MULDIV_LAT-1; keep at least one bit.
    localparam int CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
    localparam logic [5:0] FUNC_MULT = 6'b011000;
    localparam logic [5:0] FUNC_DIV  = 6'b011010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q,      state_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic [DATA_W-1:0]   op_a_q,       op_a_d;
    logic [DATA_W-1:0]   op_b_q,       op_b_d;
    logic [5:0]          op_func_q,    op_func_d;
    logic                op_id_q,      op_id_d;
    logic                last_grant_q, last_grant_d;
    logic [DATA_W-1:0]   rsp_data_q,   rsp_data_d;
    logic                rsp_zero_q,   rsp_zero_d;

    // Requester inputs packed into arrays so the selection below can be indexed
    logic [1:0]          req_valid;
    logic [DATA_W-1:0]   req_a    [2];
    logic [DATA_W-1:0]   req_b    [2];
    logic [5:0]          req_func [2];
    logic [1:0]          req_ready_w;

    assign req_valid   = {req1_valid, req0_valid};
    assign req_a[0]    = req0_a;
    assign req_a[1]    = req1_a;
    assign req_b[0]    = req0_b;
    assign req_b[1]    = req1_b;
    assign req_func[0] = req0_func;
    assign req_func[1] = req1_func;

    // Round-robin choice: on a tie, the requester that did not win last time
    // gets the grant. With a single valid requester, that requester wins.
    logic grant_valid;
    logic grant_id;
    assign grant_valid = |req_valid;
    assign grant_id    = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];

    // A ready is raised only while idle, and only toward the chosen requester.
    // This keeps the two readies one-hot or zero.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready_w[gi] = (state_q == S_IDLE) && grant_valid &&
                                     (grant_id == 1'(gi));
        end
    endgenerate

    assign req0_ready = req_ready_w[0];
    assign req1_ready = req_ready_w[1];

    logic sel_muldiv;
    assign sel_muldiv = (req_func[grant_id] == FUNC_MULT) ||
                        (req_func[grant_id] == FUNC_DIV);

    // Next-state logic: accept an op, count down the execute time, then hold
    // the response until the consumer takes it.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_func_d    = op_func_q;
        op_id_d      = op_id_q;
        last_grant_d = last_grant_q;
        rsp_data_d   = rsp_data_q;
        rsp_zero_d   = rsp_zero_q;
        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    op_a_d       = req_a[grant_id];
                    op_b_d       = req_b[grant_id];
                    op_func_d    = req_func[grant_id];
                    op_id_d      = grant_id;
                    last_grant_d = grant_id;
                    cnt_d        = sel_muldiv ? CNT_W'(MULDIV_LAT - 1) : '0;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rsp_data_d = alu_out;
                    rsp_zero_d = alu_zero;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers. Reset discards any in-flight op or pending
    // response. Reset also lets requester 0 win the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_func_q    <= '0;
            op_id_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_func_q    <= op_func_d;
            op_id_q      <= op_id_d;
            last_grant_q <= last_grant_d;
            rsp_data_q   <= rsp_data_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign alu_in1   = op_a_q;
    assign alu_in2   = op_b_q;
    assign alu_func  = op_func_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = op_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign busy      = (state_q != S_IDLE);

endmodule
